// File: rtl/tile_order_checker.sv
// Board-shuffle consumer: verifies the edge and center tile orders are permutations,
// then serves forward (position -> picture) and inverse (picture -> position) lookups.
module tile_order_checker #(
    parameter int EDGE_N   = 24,
    parameter int CENTER_N = 12,
    parameter int IDX_W    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [EDGE_N*IDX_W-1:0]   edge_order_in,
    input  logic [CENTER_N*IDX_W-1:0] center_order_in,
    output logic                      busy,
    output logic                      order_valid,
    output logic                      order_error,
    output logic                      err_center,
    output logic [IDX_W-1:0]          err_index,
    input  logic                      rd_req,
    input  logic                      rd_sel,
    input  logic                      rd_inv,
    input  logic [IDX_W-1:0]          rd_key,
    output logic                      rd_ack,
    output logic [IDX_W-1:0]          rd_data,
    output logic                      rd_err
);
    localparam int CW = $clog2(CENTER_N);
    localparam logic [IDX_W-1:0] EDGE_LIM    = IDX_W'(EDGE_N);
    localparam logic [IDX_W-1:0] CENTER_LIM  = IDX_W'(CENTER_N);
    localparam logic [IDX_W-1:0] EDGE_LAST   = IDX_W'(EDGE_N - 1);
    localparam logic [IDX_W-1:0] CENTER_LAST = IDX_W'(CENTER_N - 1);

    typedef enum logic [2:0] {IDLE, CHK_EDGE, CHK_CENTER, READY, ERROR} state_t;

    state_t state_q, state_d;

    logic [EDGE_N*IDX_W-1:0]   edge_q;
    logic [CENTER_N*IDX_W-1:0] center_q;
    logic [EDGE_N-1:0]         seen_e_q;
    logic [CENTER_N-1:0]       seen_c_q;
    logic [IDX_W-1:0]          inv_e_q [EDGE_N];
    logic [IDX_W-1:0]          inv_c_q [CENTER_N];
    logic [IDX_W-1:0]          idx_q;
    logic                      err_center_q;
    logic [IDX_W-1:0]          err_index_q;

    logic                      req_q, pend_err_q;
    logic [IDX_W-1:0]          pend_data_q;
    logic                      rd_ack_q, rd_err_q;
    logic [IDX_W-1:0]          rd_data_q;

    logic [IDX_W-1:0]          edge_f   [EDGE_N];
    logic [IDX_W-1:0]          center_f [CENTER_N];
    logic [IDX_W-1:0]          cur_e, cur_c, lk_data;
    logic                      load_ok, e_bad, c_bad, key_ok, lk_ok;

    for (genvar g = 0; g < EDGE_N; g++) begin : g_edge
        assign edge_f[g] = edge_q[g*IDX_W +: IDX_W];
    end
    for (genvar g = 0; g < CENTER_N; g++) begin : g_center
        assign center_f[g] = center_q[g*IDX_W +: IDX_W];
    end

    always_comb begin
        state_d = state_q;
        load_ok = load && (state_q == IDLE || state_q == READY || state_q == ERROR);
        cur_e   = edge_f[idx_q];
        cur_c   = (idx_q < CENTER_LIM) ? center_f[idx_q[CW-1:0]] : '0;
        // Range test first so the seen lookup never indexes past the bitmap.
        e_bad   = (cur_e >= EDGE_LIM) ? 1'b1 : seen_e_q[cur_e];
        c_bad   = (cur_c >= CENTER_LIM) ? 1'b1 : seen_c_q[cur_c[CW-1:0]];
        case (state_q)
            IDLE, READY, ERROR: if (load_ok) state_d = CHK_EDGE;
            CHK_EDGE: begin
                if (e_bad)                   state_d = ERROR;
                else if (idx_q == EDGE_LAST) state_d = CHK_CENTER;
            end
            CHK_CENTER: begin
                if (c_bad)                     state_d = ERROR;
                else if (idx_q == CENTER_LAST) state_d = READY;
            end
            default: state_d = IDLE;
        endcase
    end

    // A load accepted on the same edge as a request makes that request stale: reject it.
    always_comb begin
        key_ok  = rd_sel ? (rd_key < CENTER_LIM) : (rd_key < EDGE_LIM);
        lk_ok   = rd_req && (state_q == READY) && !load && key_ok;
        lk_data = '0;
        if (lk_ok) begin
            case ({rd_sel, rd_inv})
                2'b00:   lk_data = edge_f[rd_key];
                2'b01:   lk_data = inv_e_q[rd_key];
                2'b10:   lk_data = center_f[rd_key[CW-1:0]];
                default: lk_data = inv_c_q[rd_key[CW-1:0]];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_q       <= '0;
            center_q     <= '0;
            seen_e_q     <= '0;
            seen_c_q     <= '0;
            idx_q        <= '0;
            err_center_q <= 1'b0;
            err_index_q  <= '0;
            for (int i = 0; i < EDGE_N; i++)   inv_e_q[i] <= '0;
            for (int i = 0; i < CENTER_N; i++) inv_c_q[i] <= '0;
        end else if (load_ok) begin
            edge_q       <= edge_order_in;
            center_q     <= center_order_in;
            seen_e_q     <= '0;
            seen_c_q     <= '0;
            idx_q        <= '0;
            err_center_q <= 1'b0;
            err_index_q  <= '0;
        end else if (state_q == CHK_EDGE) begin
            if (e_bad) begin
                err_center_q <= 1'b0;
                err_index_q  <= idx_q;
            end else begin
                seen_e_q[cur_e] <= 1'b1;
                inv_e_q[cur_e]  <= idx_q;
                idx_q           <= (idx_q == EDGE_LAST) ? '0 : idx_q + 1'b1;
            end
        end else if (state_q == CHK_CENTER) begin
            if (c_bad) begin
                err_center_q <= 1'b1;
                err_index_q  <= idx_q;
            end else begin
                seen_c_q[cur_c[CW-1:0]] <= 1'b1;
                inv_c_q[cur_c[CW-1:0]]  <= idx_q;
                idx_q                   <= idx_q + 1'b1;
            end
        end
    end

    // Two-stage response: result computed at the sampling edge, presented one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q       <= 1'b0;
            pend_err_q  <= 1'b0;
            pend_data_q <= '0;
            rd_ack_q    <= 1'b0;
            rd_err_q    <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            req_q       <= rd_req;
            pend_err_q  <= rd_req && !lk_ok;
            pend_data_q <= lk_data;
            rd_ack_q    <= req_q;
            rd_err_q    <= req_q && pend_err_q;
            rd_data_q   <= req_q ? pend_data_q : '0;
        end
    end

    assign busy        = (state_q == CHK_EDGE) || (state_q == CHK_CENTER);
    assign order_valid = (state_q == READY);
    assign order_error = (state_q == ERROR);
    assign err_center  = err_center_q;
    assign err_index   = err_index_q;
    assign rd_ack      = rd_ack_q;
    assign rd_err      = rd_err_q;
    assign rd_data     = rd_data_q;
endmodule

// File: tb/tb_tile_order_checker.sv
// Directed bench for tile_order_checker: status timing checked inline, lookup
// responses checked by a scoreboard monitor against an expected queue.
module tb_tile_order_checker;
    logic         clk = 1'b0;
    logic         rst, load;
    logic [119:0] edge_order_in;
    logic [59:0]  center_order_in;
    logic         busy, order_valid, order_error, err_center;
    logic [4:0]   err_index;
    logic         rd_req, rd_sel, rd_inv;
    logic [4:0]   rd_key;
    logic         rd_ack, rd_err;
    logic [4:0]   rd_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    // {ack cycle[31:0], rd_err, rd_data[4:0]}
    logic [37:0] exp_q[$];

    tile_order_checker dut (
        .clk(clk), .rst(rst), .load(load),
        .edge_order_in(edge_order_in), .center_order_in(center_order_in),
        .busy(busy), .order_valid(order_valid), .order_error(order_error),
        .err_center(err_center), .err_index(err_index),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_inv(rd_inv), .rd_key(rd_key),
        .rd_ack(rd_ack), .rd_data(rd_data), .rd_err(rd_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rd_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack err=%0d data=%0d expected none (cycle %0d)",
                         rd_err, rd_data, cyc);
            end else begin
                logic [37:0] ex;
                ex = exp_q.pop_front();
                chk("ack_cycle", cyc, int'(ex[37:6]));
                chk("rd_err", rd_err, ex[5]);
                chk("rd_data", rd_data, ex[4:0]);
            end
        end else if (rd_err || rd_data != 5'd0) begin
            checks++;
            errors++;
            $display("FAIL idle_outputs: got err=%0d data=%0d expected 0 0 (cycle %0d)",
                     rd_err, rd_data, cyc);
        end
    end

    function automatic logic [119:0] edge_vec(input bit rev);
        logic [119:0] v;
        for (int i = 0; i < 24; i++) v[i*5 +: 5] = rev ? 5'(23 - i) : 5'(i);
        return v;
    endfunction

    function automatic logic [59:0] center_vec(input bit rev);
        logic [59:0] v;
        for (int i = 0; i < 12; i++) v[i*5 +: 5] = rev ? 5'(11 - i) : 5'(i);
        return v;
    endfunction

    task automatic do_load(input logic [119:0] ev, input logic [59:0] cv);
        edge_order_in   = ev;
        center_order_in = cv;
        load            = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic lookup(input logic s, input logic v, input logic [4:0] k,
                          input logic e, input logic [4:0] d);
        rd_req = 1'b1; rd_sel = s; rd_inv = v; rd_key = k;
        exp_q.push_back({32'(cyc + 2), e, d});
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic chk_status(input string nm, input logic b, input logic v, input logic e);
        chk({nm, "_busy"}, busy, b);
        chk({nm, "_valid"}, order_valid, v);
        chk({nm, "_error"}, order_error, e);
    endtask

    task automatic drain(input string nm);
        repeat (4) @(negedge clk);
        chk({nm, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [119:0] ev;
        logic [59:0]  cv;
        rst = 1'b1; load = 1'b0; rd_req = 1'b0; rd_sel = 1'b0; rd_inv = 1'b0; rd_key = '0;
        edge_order_in = '0; center_order_in = '0;
        repeat (3) @(negedge clk);
        chk_status("reset", 0, 0, 0);
        chk("reset_err_center", err_center, 0);
        chk("reset_err_index", err_index, 0);
        chk("reset_rd_ack", rd_ack, 0);
        rst = 1'b0;
        lookup(0, 0, 5'd1, 1, 5'd0);
        drain("idle");

        // identity orders
        do_load(edge_vec(0), center_vec(0));
        chk_status("id_start", 1, 0, 0);
        repeat (35) @(negedge clk);
        chk_status("id_e35", 1, 0, 0);
        @(negedge clk);
        chk_status("id_e36", 0, 1, 0);
        lookup(0, 0, 5'd5, 0, 5'd5);
        lookup(1, 1, 5'd7, 0, 5'd7);
        drain("id");

        // reversed orders, back-to-back lookups and key boundaries
        do_load(edge_vec(1), center_vec(1));
        repeat (36) @(negedge clk);
        chk_status("rev_done", 0, 1, 0);
        lookup(0, 1, 5'd0, 0, 5'd23);
        lookup(1, 0, 5'd2, 0, 5'd9);
        lookup(1, 1, 5'd11, 0, 5'd0);
        lookup(0, 0, 5'd23, 0, 5'd0);
        lookup(0, 1, 5'd23, 0, 5'd0);
        lookup(1, 0, 5'd11, 0, 5'd0);
        lookup(0, 0, 5'd24, 1, 5'd0);
        lookup(1, 0, 5'd12, 1, 5'd0);
        lookup(1, 1, 5'd31, 1, 5'd0);
        drain("rev");

        // load and rd_req on the same edge in READY, then a reload attempt mid-check
        edge_order_in = edge_vec(0); center_order_in = center_vec(0); load = 1'b1;
        rd_req = 1'b1; rd_sel = 1'b0; rd_inv = 1'b0; rd_key = 5'd3;
        exp_q.push_back({32'(cyc + 2), 1'b1, 5'd0});
        @(negedge clk);
        load = 1'b0; rd_req = 1'b0;
        chk_status("ldreq_start", 1, 0, 0);
        repeat (9) @(negedge clk);
        do_load(edge_vec(1), center_vec(1));
        repeat (25) @(negedge clk);
        chk_status("reload_e35", 1, 0, 0);
        @(negedge clk);
        chk_status("reload_e36", 0, 1, 0);
        lookup(0, 0, 5'd4, 0, 5'd4);
        lookup(1, 0, 5'd4, 0, 5'd4);
        drain("reload");

        // duplicate in edge field 7
        ev = edge_vec(0);
        ev[7*5 +: 5] = 5'd3;
        do_load(ev, center_vec(0));
        repeat (7) @(negedge clk);
        chk_status("dup_e7", 1, 0, 0);
        @(negedge clk);
        chk_status("dup_e8", 0, 0, 1);
        chk("dup_err_center", err_center, 0);
        chk("dup_err_index", err_index, 7);
        lookup(0, 0, 5'd1, 1, 5'd0);
        lookup(1, 1, 5'd1, 1, 5'd0);
        drain("dup");

        // out-of-range value in center field 4, loaded from ERROR
        cv = center_vec(0);
        cv[4*5 +: 5] = 5'd12;
        do_load(edge_vec(1), cv);
        repeat (28) @(negedge clk);
        chk_status("cen_e28", 1, 0, 0);
        @(negedge clk);
        chk_status("cen_e29", 0, 0, 1);
        chk("cen_err_center", err_center, 1);
        chk("cen_err_index", err_index, 4);
        drain("cen");

        // reset mid-check
        do_load(edge_vec(0), center_vec(0));
        repeat (19) @(negedge clk);
        chk_status("rst_e19", 1, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk_status("rst_e20", 0, 0, 0);
        chk("rst_err_center", err_center, 0);
        chk("rst_err_index", err_index, 0);
        rst = 1'b0;
        lookup(0, 0, 5'd2, 1, 5'd0);
        drain("rst");
        chk_status("rst_idle", 0, 0, 0);

        // recovery from IDLE
        do_load(edge_vec(1), center_vec(0));
        repeat (36) @(negedge clk);
        chk_status("rec_done", 0, 1, 0);
        lookup(0, 1, 5'd0, 0, 5'd23);
        lookup(1, 0, 5'd6, 0, 5'd6);
        drain("rec");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
